// File: rtl/fetch_exec_ctrl.sv
// Instruction-sequencing FSM for the 8-bit CPU: two-byte fetch over a byte-wide read
// handshake, decode, ALU/register-file strobes and a single PC update per instruction.
module fetch_exec_ctrl #(
  parameter int PC_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] pc,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_valid,
  input  logic            zero_flag,
  output logic [15:0]     ir,
  output logic            alu_en,
  output logic            reg_we,
  output logic            PC_en,
  output logic            jump_en,
  output logic [PC_W-1:0] next_pc_value,
  output logic            halted,
  output logic            illegal_op,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH0  = 3'd1,
    S_FETCH1  = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_WB      = 3'd5,
    S_ADVANCE = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       jump_q;
  logic [3:0] opcode;
  logic       op_illegal;

  assign opcode        = ir[15:12];
  assign op_illegal    = !(opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
  assign next_pc_value = {ir[PC_W-1:1], 1'b0};
  assign state_dbg     = state;

  // Read handshake: a byte transfers on every cycle where mem_req and mem_valid are both
  // high; mem_req and mem_addr stay fixed until then, and mem_valid is ignored otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ir     <= '0;
      jump_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH0 && mem_valid) ir[15:8] <= mem_rdata;
      if (state == S_FETCH1 && mem_valid) ir[7:0]  <= mem_rdata;
      if (state == S_DECODE)
        jump_q <= (opcode == 4'h3) || (opcode == 4'h4 && zero_flag);
    end
  end

  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    PC_en      = 1'b0;
    jump_en    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_FETCH0;
      S_FETCH0: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_valid) state_nx = S_FETCH1;
      end
      S_FETCH1: begin
        mem_req  = 1'b1;
        mem_addr = pc + PC_W'(1);
        if (mem_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        illegal_op = op_illegal;
        case (opcode)
          4'h1:    state_nx = S_EXEC;
          4'h2:    state_nx = S_WB;
          4'hF:    state_nx = S_HALT;
          default: state_nx = S_ADVANCE;
        endcase
      end
      S_EXEC: begin
        alu_en   = 1'b1;
        state_nx = S_WB;
      end
      S_WB: begin
        reg_we   = 1'b1;
        state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        PC_en    = 1'b1;
        jump_en  = jump_q;
        state_nx = S_FETCH0;
      end
      S_HALT: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Bench for fetch_exec_ctrl: program memory with random wait states, a PC register model,
// and a per-instruction scoreboard fed by a program-level reference model.
module tb_fetch_exec_ctrl;
  localparam int PC_W = 3;
  localparam int W    = 28;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] pc;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_rdata;
  logic            mem_valid;
  logic            zero_flag;
  logic [15:0]     ir;
  logic            alu_en, reg_we, PC_en, jump_en;
  logic [PC_W-1:0] next_pc_value;
  logic            halted, illegal_op;
  logic [2:0]      state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   mem [8];
  int           fixed_wait = 0;
  bit           rand_wait  = 1'b0;
  bit           mon_en     = 1'b0;
  int           last_win_len = 0;

  fetch_exec_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .zero_flag(zero_flag), .ir(ir), .alu_en(alu_en), .reg_we(reg_we), .PC_en(PC_en),
    .jump_en(jump_en), .next_pc_value(next_pc_value), .halted(halted),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program counter register driven by the strobes.
  initial begin
    pc = '0;
    forever begin
      @(negedge clk);
      if (rst_n && PC_en) pc = jump_en ? next_pc_value : pc + 3'd2;
    end
  end

  // Memory responder with configurable wait states.
  initial begin
    int cnt;
    bit pending;
    cnt = 0; pending = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !mem_req) begin
        mem_valid = 1'b0;
        pending   = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          cnt = rand_wait ? $urandom_range(0, 2) : fixed_wait;
        end
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem[mem_addr];
          pending   = 1'b0;
        end else begin
          mem_valid = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Monitor: one record per instruction, closed by PC_en or by entering halt.
  int win_len, win_wait;
  bit s_alu, s_reg, s_ill, s_multi, halt_seen;
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (!rst_n || start) begin
      win_len = 0; win_wait = 0;
      s_alu = 0; s_reg = 0; s_ill = 0; s_multi = 0;
      if (!rst_n) halt_seen = 0;
    end else if (mon_en) begin
      win_len++;
      if (mem_req && !mem_valid) win_wait++;
      s_alu |= alu_en;
      s_reg |= reg_we;
      s_ill |= illegal_op;
      if (int'(alu_en) + int'(reg_we) + int'(PC_en) + int'(illegal_op) > 1) s_multi = 1;
      if (PC_en || (halted && !halt_seen)) begin
        got = {ir, jump_en, next_pc_value, s_alu, s_reg, s_ill, halted,
               3'(win_len - win_wait), s_multi};
        if (exp_q.size() == 0) check("spurious_event", 32'(got), 32'h0);
        else check("instr_record", 32'(got), 32'(exp_q.pop_front()));
        last_win_len = win_len;
        if (halted) halt_seen = 1;
        win_len = 0; win_wait = 0;
        s_alu = 0; s_reg = 0; s_ill = 0; s_multi = 0;
      end
    end
  end

  // Reference model: walks the program instruction by instruction.
  function automatic void model(input logic [PC_W-1:0] pc0, input bit zf, input int k);
    logic [PC_W-1:0] p, q, tgt;
    logic [7:0] op_b, opr_b;
    bit jmp, alu, wr, ill, hlt;
    int lat;
    p = pc0;
    for (int n = 0; n < k; n++) begin
      q = p + 3'd1;
      op_b = mem[p]; opr_b = mem[q];
      jmp = 0; alu = 0; wr = 0; ill = 0; hlt = 0; lat = 4;
      case (op_b[7:4])
        4'h0: ;
        4'h1: begin alu = 1; wr = 1; lat = 6; end
        4'h2: begin wr = 1; lat = 5; end
        4'h3: jmp = 1;
        4'h4: jmp = zf;
        4'hF: hlt = 1;
        default: ill = 1;
      endcase
      tgt = opr_b[2:0] & 3'b110;
      exp_q.push_back({op_b, opr_b, jmp, tgt, alu, wr, ill, hlt, 3'(lat), 1'b0});
      if (hlt) break;
      p = jmp ? tgt : p + 3'd2;
    end
  endfunction

  task automatic do_reset();
    #1;
    rst_n = 1'b0; start = 1'b0; mon_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_prog(input logic [PC_W-1:0] pc0, input bit zf, input int k, input int wmode);
    int c;
    do_reset();
    pc = pc0; zero_flag = zf;
    rand_wait  = (wmode < 0);
    fixed_wait = (wmode < 0) ? 0 : wmode;
    mon_en = 1'b1;
    model(pc0, zf, k);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      check("run_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({mem_req, mem_addr, ir, alu_en, reg_we, PC_en, jump_en,
                next_pc_value, halted, illegal_op});
  endfunction

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 13);
    case (r)
      0, 1:    return {4'h0, 4'(r)};
      2, 3:    return 8'h10 | 8'($urandom_range(0, 15));
      4, 5:    return 8'h20 | 8'($urandom_range(0, 15));
      6, 7:    return 8'h30;
      8, 9:    return 8'h40;
      10:      return 8'hF0;
      default: return {4'($urandom_range(5, 14)), 4'h0};
    endcase
  endfunction

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; zero_flag = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset state, then asynchronous reset in the middle of the second read.
    do_reset();
    check("reset_outputs", out_vec(), 32'h0);
    mem[3] = 8'h12; mem[4] = 8'h34;
    pc = 3'd3; fixed_wait = 3; rand_wait = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (!(mem_req && mem_addr == 3'd4) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("reach_fetch1", 32'(mem_req && mem_addr == 3'd4), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", out_vec(), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_req", 32'({mem_req, mem_addr}), 32'({1'b1, 3'd3}));

    // NOP with zero-wait memory.
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    run_prog(3'd0, 1'b0, 1, 0);
    check("nop_cycles", 32'(last_win_len), 32'd4);

    // ALU with two wait cycles per byte.
    mem[0] = 8'h12; mem[1] = 8'h34;
    run_prog(3'd0, 1'b0, 1, 2);
    check("alu_total_cycles", 32'(last_win_len), 32'd10);

    // JZ taken and not taken.
    mem[0] = 8'h40; mem[1] = 8'h05;
    run_prog(3'd0, 1'b1, 1, 0);
    run_prog(3'd0, 1'b0, 1, 0);

    // Address wrap with an illegal opcode.
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    mem[7] = 8'h70; mem[0] = 8'h5A;
    run_prog(3'd7, 1'b0, 1, 0);

    // HLT: sticky, start ignored, no strobes until reset.
    mem[0] = 8'hF0; mem[1] = 8'h00;
    run_prog(3'd0, 1'b0, 3, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 start = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check("halt_hold", 32'({halted, PC_en, mem_req, alu_en, reg_we}), 32'b10000);
    end
    start = 1'b0;
    do_reset();
    check("halt_cleared", 32'(halted), 32'h0);

    // Randomized programs.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i += 2) begin
        mem[i]   = rand_op();
        mem[i+1] = 8'($urandom_range(0, 255));
      end
      run_prog(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               $urandom_range(1, 6), $urandom_range(0, 3) - 1);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
